branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Fetch-side companion to the EX-stage branch decision: predicts B-type outcomes at IF and
//  is trained by the actual taken/not-taken result computed in EX.
//  Uses a bimodal table of 2-bit saturating counters (BHT).
//  An in-order FIFO holds outstanding predictions until each one is resolved.
//  On resolution the block raises a registered mispredict pulse that drives the pipeline flush.
// PARAMETERS
//  IDX_W       6   BHT index width; BHT has 2**IDX_W entries
//  FIFO_DEPTH  4   max in-flight (predicted, unresolved) branches; power of 2, >=2
// PORTS
//  clk         in   1                        clock, rising edge
//  rst         in   1                        synchronous reset, active-high
//  pred_valid  in   1                        IF holds a B-type instr at pred_pc
//  pred_pc     in   32                       PC of that instruction
//  pred_ready  out  1                        room in FIFO; prediction accepted when valid&ready
//  pred_taken  out  1                        combinational prediction = BHT[idx][1]
//  res_valid   in   1                        EX resolves the oldest outstanding branch
//  res_taken   in   1                        actual outcome from EX branch-decision logic
//  flush       in   1                        discard all outstanding predictions
//  mispredict  out  1                        registered 1-cycle pulse: prediction was wrong
//  res_error   out  1                        sticky: res_valid seen with FIFO empty
//  occupancy   out  $clog2(FIFO_DEPTH)+1     entries currently in FIFO
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge):
//   - all BHT counters := 2'b01 (weakly not-taken); FIFO empty; occupancy=0.
//   - mispredict=0, res_error=0, pred_ready=1. Applies equally mid-operation; in-flight state lost.
//  Index:
//   - idx = pred_pc[IDX_W+1:2]; pred_pc[1:0] ignored.
//   - pred_taken is valid whenever pred_pc is stable, independent of pred_valid.
//  Push:
//   - on pred_valid & pred_ready, store {idx, pred_taken} at tail.
//   - pred_ready = (occupancy != FIFO_DEPTH). A full FIFO does not accept a push even with a
//     same-cycle pop (no bypass).
//  Pop:
//   - on res_valid & (occupancy != 0), read head {h_idx, h_pred}.
//   - BHT[h_idx] saturating update: taken -> min(c+1,3); not taken -> max(c-1,0).
//   - next cycle mispredict = (h_pred != res_taken); otherwise mispredict = 0.
//  Empty resolve:
//   - res_valid with occupancy==0 sets res_error=1, held until rst.
//   - no BHT update; mispredict stays 0.
//  Simultaneous push+pop (not full, not empty): occupancy unchanged; pointers wrap mod FIFO_DEPTH.
//  BHT read/write same index, same cycle: pred_taken uses the pre-update counter.
//   - Update is visible the next cycle. Push stores that pre-update prediction.
//  Flush:
//   - a same-cycle valid pop is still fully processed (BHT update + mispredict).
//   - FIFO is then emptied (occupancy=0 next cycle); a same-cycle push is dropped.
//   - BHT contents are kept.
//  Latency:
//   - prediction: 0 cycles (combinational).
//   - mispredict: 1 cycle after the resolving edge.
//   - BHT update: visible 1 cycle after the pop.
// TESTING
//  1 Reset -> pred_taken=0 for any pc; occupancy=0; pred_ready=1; mispredict=0; res_error=0.
//  2 Training, pc=0x40, 3 rounds of push+resolve(taken=1):
//     - rounds 1-2 predict 0 with mispredict=1; round 3 predicts 1 with mispredict=0.
//     - counter saturates at 3.
//  3 Four pushes, no resolve -> occupancy=4, pred_ready=0; 5th pred_valid not stored.
//     One resolve -> occupancy=3, pred_ready=1.
//  4 Push/pop same cycle at occupancy=2, 20 iterations -> occupancy stays 2;
//     pointer wrap correct; mispredicts match a reference model.
//  5 Flush with occupancy=3 and concurrent resolve(taken=1, pred=0):
//     - mispredict=1 next cycle; occupancy=0.
//     - concurrent push not stored.
//  6 res_valid at occupancy=0 -> res_error=1 sticky, BHT unchanged; rst mid-stream clears all.

Source files
------------

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2-bit counter BHT trained from EX results,
// with an in-order FIFO of outstanding predictions.
module branch_predictor #(
  parameter int IDX_W      = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pred_valid,
  input  logic [31:0]                   pred_pc,
  output logic                          pred_ready,
  output logic                          pred_taken,
  input  logic                          res_valid,
  input  logic                          res_taken,
  input  logic                          flush,
  output logic                          mispredict,
  output logic                          res_error,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int ENT = 2 ** IDX_W;
  localparam logic [PW:0] FULL = (PW + 1)'(FIFO_DEPTH);

  logic [1:0]       bht   [ENT];
  logic [IDX_W-1:0] q_idx [FIFO_DEPTH];
  logic             q_pred[FIFO_DEPTH];

  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] h_idx;
  logic             h_pred;
  logic [1:0]       ctr;
  logic             push;
  logic             pop;
  logic             unused_pc;

  assign idx        = pred_pc[IDX_W+1:2];
  assign unused_pc  = ^{pred_pc[31:IDX_W+2], pred_pc[1:0]};
  assign pred_taken = bht[idx][1];
  assign pred_ready = (occupancy != FULL);

  // A flushed push is dropped; a flushed pop still trains the BHT.
  assign push   = pred_valid & pred_ready & ~flush;
  assign pop    = res_valid & (occupancy != '0);
  assign h_idx  = q_idx[head];
  assign h_pred = q_pred[head];
  assign ctr    = bht[h_idx];

  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[tail]  <= idx;
      q_pred[tail] <= pred_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENT; i++)
        bht[i] <= 2'b01;
    end else if (pop) begin
      if (res_taken) begin
        if (ctr != 2'b11)
          bht[h_idx] <= ctr + 2'b01;
      end else begin
        if (ctr != 2'b00)
          bht[h_idx] <= ctr - 2'b01;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      occupancy  <= '0;
      mispredict <= 1'b0;
      res_error  <= 1'b0;
    end else begin
      mispredict <= pop & (h_pred != res_taken);
      if (res_valid && occupancy == '0)
        res_error <= 1'b1;
      if (flush) begin
        head      <= '0;
        tail      <= '0;
        occupancy <= '0;
      end else begin
        if (push)
          tail <= tail + 1'b1;
        if (pop)
          head <= head + 1'b1;
        unique case ({push, pop})
          2'b10:   occupancy <= occupancy + 1'b1;
          2'b01:   occupancy <= occupancy - 1'b1;
          default: occupancy <= occupancy;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed vectors, expected
// mispredicts queued at issue time and checked by a separate monitor.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_ready;
  logic        pred_taken;
  logic        res_valid;
  logic        res_taken;
  logic        flush;
  logic        mispredict;
  logic        res_error;
  logic [2:0]  occupancy;

  branch_predictor #(.IDX_W(6), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pred_valid (pred_valid),
    .pred_pc    (pred_pc),
    .pred_ready (pred_ready),
    .pred_taken (pred_taken),
    .res_valid  (res_valid),
    .res_taken  (res_taken),
    .flush      (flush),
    .mispredict (mispredict),
    .res_error  (res_error),
    .occupancy  (occupancy)
  );

  typedef struct {
    int idx;
    bit pred;
  } ent_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   bm[64];
  ent_t mq[$];
  bit   sb[$];
  bit   m_err;
  bit   pop_flag;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Monitor: after each edge, compare mispredict with the queued expectation.
  initial begin
    bit p;
    bit e;
    forever begin
      @(posedge clk);
      p = pop_flag;
      @(negedge clk);
      if (p) begin
        if (sb.size() == 0) begin
          e = 1'b0;
          check("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
        end
        check("mispredict", mispredict, e);
      end else begin
        check("mispredict_idle", mispredict, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1;
    pred_valid = 1'b0;
    pred_pc = 32'h0;
    res_valid = 1'b0;
    res_taken = 1'b0;
    flush = 1'b0;
    pop_flag = 1'b0;
    foreach (bm[i]) bm[i] = 1;
    mq.delete();
    m_err = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drive(input bit pv, input logic [31:0] pc, input bit rv,
                       input bit rt, input bit fl);
    int   ix;
    bit   pt;
    bit   full;
    bit   empty;
    ent_t h;
    ix    = int'(pc[7:2]);
    pt    = (bm[ix] >= 2);
    full  = (mq.size() == 4);
    empty = (mq.size() == 0);
    pred_valid = pv;
    pred_pc    = pc;
    res_valid  = rv;
    res_taken  = rt;
    flush      = fl;
    pop_flag   = 1'b0;
    if (rv && empty)
      m_err = 1'b1;
    if (rv && !empty) begin
      h = mq.pop_front();
      sb.push_back(h.pred != rt);
      pop_flag = 1'b1;
      if (rt) begin
        if (bm[h.idx] < 3) bm[h.idx]++;
      end else begin
        if (bm[h.idx] > 0) bm[h.idx]--;
      end
    end
    if (pv && !full && !fl)
      mq.push_back('{ix, pt});
    if (fl)
      mq.delete();
    #1;
    check("pred_taken", pred_taken, pt);
    @(posedge clk);
    #1;
    check("occupancy", occupancy, mq.size());
    check("pred_ready", pred_ready, mq.size() != 4);
    check("res_error", res_error, m_err);
  endtask

  initial begin
    do_reset();
    check("rst_occ", occupancy, 0);
    check("rst_ready", pred_ready, 1);
    check("rst_mis", mispredict, 0);
    check("rst_err", res_error, 0);
    pred_pc = 32'h40;
    #1 check("rst_pred_40", pred_taken, 0);
    pred_pc = 32'hFFFF_FFFF;
    #1 check("rst_pred_ff", pred_taken, 0);

    // Training at 0x40: each push overlaps the previous resolve.
    drive(1, 32'h40, 0, 0, 0);
    drive(1, 32'h40, 1, 1, 0);
    drive(1, 32'h40, 1, 1, 0);
    drive(0, 32'h40, 1, 1, 0);
    check("train_pred", pred_taken, 1);
    drive(1, 32'h40, 0, 0, 0);
    drive(0, 32'h40, 1, 1, 0);
    drive(1, 32'h40, 0, 0, 0);
    drive(0, 32'h40, 1, 0, 0);
    check("sat_pred", pred_taken, 1);

    // Fill to full; fifth push refused.
    drive(1, 32'h10, 0, 0, 0);
    drive(1, 32'h14, 0, 0, 0);
    drive(1, 32'h18, 0, 0, 0);
    drive(1, 32'h1c, 0, 0, 0);
    drive(1, 32'h40, 0, 0, 0);
    check("full_occ", occupancy, 4);
    check("full_ready", pred_ready, 0);
    drive(0, 32'h0, 1, 0, 0);
    check("deq_occ", occupancy, 3);
    check("deq_ready", pred_ready, 1);
    drive(0, 32'h0, 1, 1, 0);
    drive(0, 32'h0, 1, 0, 0);
    drive(0, 32'h0, 1, 1, 0);

    // Steady push+pop at occupancy 2.
    drive(1, 32'h1000, 0, 0, 0);
    drive(1, 32'h1004, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'h1008 + 32'(4 * (i % 5)), 1, ((i * 7) % 3) != 0, 0);
      check("pp_occ", occupancy, 2);
    end
    drive(0, 32'h0, 1, 1, 0);
    drive(0, 32'h0, 1, 0, 0);

    // Flush with concurrent resolve and push.
    drive(1, 32'h80, 0, 0, 0);
    drive(1, 32'h84, 0, 0, 0);
    drive(1, 32'h88, 0, 0, 0);
    drive(1, 32'h8c, 1, 1, 1);
    check("flush_occ", occupancy, 0);
    drive(0, 32'h80, 0, 0, 0);
    check("flush_bht", pred_taken, 1);

    // Resolve on empty.
    drive(0, 32'h80, 1, 0, 0);
    check("empty_err", res_error, 1);
    drive(0, 32'h80, 0, 0, 0);
    check("err_sticky", res_error, 1);
    check("empty_bht", pred_taken, 1);

    // Reset mid-stream.
    drive(1, 32'h90, 0, 0, 0);
    drive(1, 32'h94, 0, 0, 0);
    do_reset();
    check("mrst_occ", occupancy, 0);
    check("mrst_err", res_error, 0);
    drive(0, 32'h40, 0, 0, 0);
    check("mrst_pred", pred_taken, 0);
    drive(0, 32'h80, 0, 0, 0);
    check("mrst_pred80", pred_taken, 0);
    drive(0, 32'h0, 0, 0, 0);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
